// File: rtl/cuckoo_match_collector.sv
// Realigns cuckoo lookup hits with packet framing, formats match records and
// buffers them in a first-word-fall-through FIFO toward the rule-report logic.
module cuckoo_match_collector #(
    parameter int LAT        = 4,
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic        byte_sop,
    input  logic        byte_eop,
    input  logic [1:0]  compare_out,
    input  logic [1:0]  suffix,
    input  logic [1:0]  compare_out_nocase,
    input  logic [1:0]  suffix_nocase,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        clear_stats,
    output logic        overflow,
    output logic        proto_err,
    output logic [15:0] drop_count
);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    state_t            state;
    logic [2:0]        dly [LAT];
    logic              a_valid, a_sop, a_eop;
    logic [6:0]        pkt_id, cur_pkt_id;
    logic              seen_sop;
    logic [15:0]       offset, cur_offset;
    logic [3:0]        hits;
    logic [31:0]       record;
    logic              accept, bad_frame, push, pop, full, write, drop;
    logic [31:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    // Framing travels alongside the lookup pipeline so it lands with its compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) dly[i] <= 3'b000;
        end else begin
            dly[0] <= {byte_valid, byte_sop, byte_eop};
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign a_valid = dly[LAT-1][2];
    assign a_sop   = dly[LAT-1][1];
    assign a_eop   = dly[LAT-1][0];

    assign hits       = {compare_out_nocase, compare_out};
    assign accept     = a_valid && (state == IN_PKT || a_sop);
    assign bad_frame  = a_valid && ((state == IN_PKT) ? a_sop : !a_sop);
    assign cur_pkt_id = a_sop ? (seen_sop ? pkt_id + 7'd1 : 7'd0) : pkt_id;
    assign cur_offset = a_sop ? 16'd0 : ((offset == 16'hFFFF) ? offset : offset + 16'd1);
    assign record     = {a_eop, cur_pkt_id, hits, suffix_nocase, suffix, cur_offset};
    assign push       = accept && ((|hits) || a_eop);

    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : 32'd0;
    assign pop     = m_valid && m_ready;
    assign full    = (count == FULL_COUNT);
    assign write   = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pkt_id     <= 7'd0;
            seen_sop   <= 1'b0;
            offset     <= 16'd0;
            overflow   <= 1'b0;
            proto_err  <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            if (accept) begin
                state  <= a_eop ? IDLE : IN_PKT;
                pkt_id <= cur_pkt_id;
                offset <= cur_offset;
                if (a_sop) seen_sop <= 1'b1;
            end
            // A drop or error in the clearing cycle still gets recorded.
            if (clear_stats) begin
                overflow   <= drop;
                proto_err  <= bad_frame;
                drop_count <= drop ? 16'd1 : 16'd0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end
                if (bad_frame) proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (write && !pop)      count <= count + COUNT_ONE;
            else if (pop && !write) count <= count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= record;
    end

endmodule

// File: tb/tb_cuckoo_match_collector.sv
// Directed bench for cuckoo_match_collector with a packet-level reference model
// and per-cycle output comparison.
module tb_cuckoo_match_collector;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic        clk, rst;
    logic        byte_valid, byte_sop, byte_eop;
    logic [1:0]  compare_out, suffix, compare_out_nocase, suffix_nocase;
    logic [31:0] m_data;
    logic        m_valid, m_ready, clear_stats;
    logic        overflow, proto_err;
    logic [15:0] drop_count;

    typedef struct packed {
        logic       v, s, e;
        logic [1:0] c, sf, cn, sfn;
    } beat_t;

    beat_t       pipe [LAT+1];
    logic [31:0] exp_q[$];
    logic [31:0] model_log[$];
    logic [31:0] got_log[$];
    bit          mdl_in_pkt, mdl_seen, mdl_ovf, mdl_perr;
    int          mdl_pkt_id, mdl_off, mdl_dc;
    bit          rdy_set;
    int          n_checks, n_pass;

    cuckoo_match_collector #(.LAT(LAT), .DEPTH(DEPTH), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_sop(byte_sop), .byte_eop(byte_eop),
        .compare_out(compare_out), .suffix(suffix),
        .compare_out_nocase(compare_out_nocase), .suffix_nocase(suffix_nocase),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .clear_stats(clear_stats), .overflow(overflow), .proto_err(proto_err),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input logic v, s, e, input logic [1:0] c, sf, cn, sfn);
        beat_t b;
        b.v = v; b.s = s; b.e = e; b.c = c; b.sf = sf; b.cn = cn; b.sfn = sfn;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_in_pkt = 0; mdl_seen = 0; mdl_pkt_id = 0; mdl_off = 0;
        mdl_ovf = 0; mdl_perr = 0; mdl_dc = 0;
        for (int i = 0; i <= LAT; i++) pipe[i] = '0;
    endtask

    // Packet-level behaviour for one aligned byte plus the consumer side of the FIFO.
    task automatic model_step(input beat_t b, input bit rdy, input bit clr);
        bit full, pop, push, drop, perr_ev;
        logic [31:0] rec;
        logic [3:0]  hits;
        rec = '0; push = 0; drop = 0; perr_ev = 0;
        full = (exp_q.size() == DEPTH);
        pop  = (exp_q.size() != 0) && rdy;
        if (b.v) begin
            if (!mdl_in_pkt && !b.s) begin
                perr_ev = 1;
            end else begin
                if (mdl_in_pkt && b.s) perr_ev = 1;
                if (b.s) begin
                    mdl_pkt_id = mdl_seen ? (mdl_pkt_id + 1) % 128 : 0;
                    mdl_seen = 1;
                    mdl_off = 0;
                end else if (mdl_off < 65535) begin
                    mdl_off++;
                end
                mdl_in_pkt = !b.e;
                hits = {b.cn, b.c};
                if (hits != 4'd0 || b.e) begin
                    rec = {b.e, 7'(mdl_pkt_id), hits, b.sfn, b.sf, 16'(mdl_off)};
                    model_log.push_back(rec);
                    push = 1;
                end
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (!full || pop) exp_q.push_back(rec);
            else drop = 1;
        end
        if (clr) begin mdl_ovf = 0; mdl_perr = 0; mdl_dc = 0; end
        if (drop) begin
            mdl_ovf = 1;
            if (mdl_dc < 65535) mdl_dc++;
        end
        if (perr_ev) mdl_perr = 1;
    endtask

    task automatic cycle(input beat_t b, input bit clr = 1'b0);
        @(negedge clk);
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
        chk("proto_err", 32'(proto_err), 32'(mdl_perr));
        chk("drop_count", 32'(drop_count), 32'(mdl_dc));
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = b;
        byte_valid = b.v; byte_sop = b.s; byte_eop = b.e;
        compare_out = pipe[LAT].c; suffix = pipe[LAT].sf;
        compare_out_nocase = pipe[LAT].cn; suffix_nocase = pipe[LAT].sfn;
        m_ready = rdy_set;
        clear_stats = clr;
        if (m_valid && m_ready) got_log.push_back(m_data);
        model_step(pipe[LAT], rdy_set, clr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0);
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) cycle('0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        model_reset();
        byte_valid = 0; byte_sop = 0; byte_eop = 0;
        compare_out = 0; suffix = 0; compare_out_nocase = 0; suffix_nocase = 0;
        clear_stats = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; rdy_set = 1'b1; m_ready = 1'b1; clear_stats = 1'b0;
        byte_valid = 0; byte_sop = 0; byte_eop = 0;
        compare_out = 0; suffix = 0; compare_out_nocase = 0; suffix_nocase = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("init_m_valid", 32'(m_valid), 32'd0);
        chk("init_m_data", m_data, 32'd0);
        chk("init_overflow", 32'(overflow), 32'd0);
        chk("init_proto_err", 32'(proto_err), 32'd0);
        chk("init_drop_count", 32'(drop_count), 32'd0);
        idle(2);

        // Single case hit at offset 5 of a 20-byte packet
        model_log.delete();
        for (int i = 0; i < 20; i++)
            cycle(mk(1, i == 0, i == 19, (i == 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b10 : 2'b00, 2'b00, 2'b00));
        idle(LAT + 2);
        chk("t1_count", 32'(model_log.size()), 32'd2);
        chk("t1_hit", model_log[0], 32'h0012_0005);
        chk("t1_eop", model_log[1], 32'h8000_0013);

        // Nocase hit coincident with eop
        model_log.delete();
        for (int i = 0; i < 8; i++)
            cycle(mk(1, i == 0, i == 7, 2'b00, 2'b00, (i == 7) ? 2'b10 : 2'b00, (i == 7) ? 2'b11 : 2'b00));
        idle(LAT + 2);
        chk("t2_count", 32'(model_log.size()), 32'd1);
        chk("t2_rec", model_log[0], 32'h818C_0007);

        // Single-byte packet followed immediately by a 3-byte packet
        model_log.delete();
        cycle(mk(1, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cycle(mk(1, i == 0, i == 2, 0, 0, 0, 0));
        idle(LAT + 2);
        chk("t3_count", 32'(model_log.size()), 32'd2);
        chk("t3_single", model_log[0], 32'h8200_0000);
        chk("t3_three", model_log[1], 32'h8300_0002);

        // Stray byte with a hit while idle: no record, framing error
        model_log.delete();
        cycle(mk(1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00));
        idle(LAT + 1);
        chk("stray_no_rec", 32'(model_log.size()), 32'd0);
        chk("stray_proto_err", 32'(proto_err), 32'd1);
        cycle('0, 1'b1);
        idle(1);
        chk("clear_proto_err", 32'(proto_err), 32'd0);

        // Overflow: consumer stalled, 20 hit bytes
        rdy_set = 1'b0;
        model_log.delete();
        for (int i = 0; i < 20; i++) cycle(mk(1, i == 0, i == 19, 2'b01, 0, 0, 0));
        idle(LAT + 2);
        chk("ovf_records", 32'(model_log.size()), 32'd20);
        chk("ovf_drop_count", 32'(drop_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        got_log.delete();
        rdy_set = 1'b1;
        drain(40);
        chk("ovf_popped", 32'(got_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("ovf_order", got_log[i], 32'h0410_0000 | 32'(i));
        cycle('0, 1'b1);
        idle(1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_drop_count", 32'(drop_count), 32'd0);

        // Restart mid-packet at offset 9
        model_log.delete();
        for (int i = 0; i < 9; i++) cycle(mk(1, i == 0, 0, 0, 0, 0, 0));
        cycle(mk(1, 1, 0, 2'b10, 0, 0, 0));
        cycle(mk(1, 0, 1, 2'b10, 0, 0, 0));
        idle(LAT + 2);
        chk("restart_count", 32'(model_log.size()), 32'd2);
        chk("restart_rec0", model_log[0], 32'h0620_0000);
        chk("restart_rec1", model_log[1], 32'h8620_0001);
        chk("restart_proto_err", 32'(proto_err), 32'd1);

        // Asynchronous reset with five records buffered mid-packet
        rdy_set = 1'b0;
        model_log.delete();
        for (int i = 0; i < 5; i++) cycle(mk(1, i == 0, 0, 2'b01, 0, 0, 0));
        idle(LAT + 1);
        chk("pre_rst_buffered", 32'(exp_q.size()), 32'd5);
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        async_reset();
        rdy_set = 1'b1;
        model_log.delete();
        got_log.delete();
        for (int i = 0; i < 3; i++) cycle(mk(1, i == 0, i == 2, (i == 0) ? 2'b01 : 2'b00, 0, 0, 0));
        idle(LAT + 3);
        chk("post_rst_count", 32'(got_log.size()), 32'd2);
        chk("post_rst_first", got_log[0], 32'h0010_0000);
        chk("post_rst_eop", got_log[1], 32'h8000_0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
